dmem_dma: RTL and testbench

//  Block-transfer engine that drives the data memory's A/WD/WE port and reads RD.

---
 rtl/dmem_dma_if.sv | 35 +++
 rtl/dmem_dma.sv | 117 +++++++++++
 tb/tb_dmem_dma.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_dma_if.sv
// Control and memory-port bundle for the dmem_dma block-transfer engine.
// The engine takes the slave side; the CPU/memory side takes the master side.
interface dmem_dma_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill_val;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  start, mode, src, dst, len,
    input  fill_val, abort, mem_rd,
    output busy, done, aborted,
    output mem_a, mem_wd, mem_we
  );

  modport master (
    output start, mode, src, dst, len,
    output fill_val, abort, mem_rd,
    input  busy, done, aborted,
    input  mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/dmem_dma.sv
// Data-memory block engine: overlap-safe copy or constant fill
// of len bytes, driving the memory A/WD/WE port while busy.
module dmem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input logic       clk,
  input logic       rst,
  dmem_dma_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, RD, WR, FILL, FIN
  } state_t;

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW:0]   CONE = (AW+1)'(1);

  state_t        state, nxt;
  logic [AW-1:0] sptr, dptr;
  logic [AW:0]   cnt;
  logic [DW-1:0] buf_q, fill_q;
  logic          desc, aborted_q;
  logic [AW-1:0] diff, lenm1, step;
  logic          desc_in, busy_s, last;

  // Destination starting inside the source window must be written top-down.
  assign diff    = bus.dst - bus.src;
  assign desc_in = (diff != '0) && ({1'b0, diff} < bus.len);
  assign lenm1   = bus.len[AW-1:0] - ONE;
  assign step    = desc ? '1 : ONE;
  assign busy_s  = (state == RD) || (state == WR) ||
                   (state == FILL);
  assign last    = (cnt == CONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sptr      <= '0;
      dptr      <= '0;
      cnt       <= '0;
      buf_q     <= '0;
      fill_q    <= '0;
      desc      <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= nxt;
      aborted_q <= busy_s && bus.abort;
      unique case (state)
        IDLE: if (bus.start) begin
          cnt    <= bus.len;
          fill_q <= bus.fill_val;
          desc   <= desc_in && !bus.mode;
          if (desc_in && !bus.mode) begin
            sptr <= bus.src + lenm1;
            dptr <= bus.dst + lenm1;
          end else begin
            sptr <= bus.src;
            dptr <= bus.dst;
          end
        end
        RD: buf_q <= bus.mem_rd;
        WR: begin
          sptr <= sptr + step;
          dptr <= dptr + step;
          cnt  <= cnt - CONE;
        end
        FILL: begin
          dptr <= dptr + ONE;
          cnt  <= cnt - CONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.start) begin
        if (bus.len == '0) nxt = FIN;
        else if (bus.mode) nxt = FILL;
        else               nxt = RD;
      end
      RD:      nxt = WR;
      WR:      nxt = last ? FIN : RD;
      FILL:    nxt = last ? FIN : FILL;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (busy_s && bus.abort) nxt = IDLE;
  end

  always_comb begin
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    bus.mem_we = 1'b0;
    unique case (state)
      RD: bus.mem_a = sptr;
      WR: begin
        bus.mem_a  = dptr;
        bus.mem_wd = buf_q;
        bus.mem_we = 1'b1;
      end
      FILL: begin
        bus.mem_a  = dptr;
        bus.mem_wd = fill_q;
        bus.mem_we = 1'b1;
      end
      default: ;
    endcase
    if (rst || bus.abort) bus.mem_we = 1'b0;
  end

  assign bus.busy    = busy_s;
  assign bus.done    = (state == FIN);
  assign bus.aborted = aborted_q;
endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: byte memory, per-cycle schedule model,
// and directed copy/fill/abort/reset scenarios.
module tb_dmem_dma;
  typedef struct {
    bit       full;
    bit       busy;
    bit       done;
    bit       ab;
    bit       we;
    bit [7:0] a;
    bit [7:0] wd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_en = 1'b0;
  logic [7:0] ld_a = '0;
  logic [7:0] ld_d = '0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  exp_t       q [$];
  logic [7:0] wq [$];
  int         cyc = 0;
  int         busy_cnt = 0;
  int         done_at = -1;
  int         errors = 0;
  int         checks = 0;
  bit         run = 1'b0;

  dmem_dma_if #(.AW(8), .DW(8)) bus ();

  dmem_dma #(.AW(8), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rd = mem[bus.mem_a];

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wd;
  end

  function automatic exp_t mk(bit f, bit b, bit d, bit ab,
                              bit we, bit [7:0] a, bit [7:0] wd);
    exp_t e;
    e.full = f; e.busy = b; e.done = d; e.ab = ab;
    e.we = we; e.a = a; e.wd = wd;
    return e;
  endfunction

  always @(negedge clk) begin : compare
    exp_t e;
    bit   ok;
    if (ld_en) ref_mem[ld_a] = ld_d;
    if (run) begin
      e = mk(1, 0, 0, 0, 0, 8'h00, 8'h00);
      if (q.size() > 0) e = q.pop_front();
      if (bus.busy) busy_cnt++;
      if (bus.done) done_at = cyc;
      if (bus.mem_we) wq.push_back(bus.mem_a);
      ok = (bus.mem_we === e.we);
      if (e.full) begin
        ok &= (bus.busy === e.busy);
        ok &= (bus.done === e.done);
        ok &= (bus.aborted === e.ab);
        if (e.busy) ok &= (bus.mem_a === e.a);
        if (e.we) ok &= (bus.mem_wd === e.wd);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL cycle %0d: got busy=%b done=%b ab=%b we=%b a=%h wd=%h want busy=%b done=%b ab=%b we=%b a=%h wd=%h",
                 cyc, bus.busy, bus.done, bus.aborted, bus.mem_we,
                 bus.mem_a, bus.mem_wd, e.busy, e.done, e.ab,
                 e.we, e.a, e.wd);
      end
      if (e.we) ref_mem[e.a] = e.wd;
    end
  end

  task automatic model_start(bit md, bit [7:0] s, bit [7:0] d,
                             int n, bit [7:0] fv);
    bit [7:0] snap [256];
    bit [7:0] diff;
    bit       desc;
    int       off;
    q.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00));
    if (n > 0 && md) begin
      for (int k = 0; k < n; k++)
        q.push_back(mk(1, 1, 0, 0, 1, d + 8'(k), fv));
    end else if (n > 0) begin
      for (int k = 0; k < n; k++) snap[k] = ref_mem[8'(s + 8'(k))];
      diff = d - s;
      desc = (diff >= 1) && (int'(diff) <= n - 1);
      for (int k = 0; k < n; k++) begin
        off = desc ? n - 1 - k : k;
        q.push_back(mk(1, 1, 0, 0, 0, s + 8'(off), 8'h00));
        q.push_back(mk(1, 1, 0, 0, 1, d + 8'(off), snap[off]));
      end
    end
    q.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'h00));
  endtask

  task automatic model_abort();
    exp_t h;
    h = q.pop_front();
    h.we = 0;
    q.delete();
    q.push_back(h);
    q.push_back(mk(1, 0, 0, 1, 0, 8'h00, 8'h00));
  endtask

  task automatic model_reset();
    q.delete();
    q.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic load(bit [7:0] a, bit [7:0] d);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic go(bit md, bit [7:0] s, bit [7:0] d,
                    int n, bit [7:0] fv);
    bus.mode     = md;
    bus.src      = s;
    bus.dst      = d;
    bus.len      = 9'(n);
    bus.fill_val = fv;
    bus.start    = 1'b1;
    model_start(md, s, d, n, fv);
    step();
    bus.start = 1'b0;
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d cycles left after %0d", q.size(), budget);
      q.delete();
    end
    step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c, w0, b0, d0, bad;
    bus.start = 0; bus.mode = 0; bus.src = '0; bus.dst = '0;
    bus.len = '0; bus.fill_val = '0; bus.abort = 0;
    repeat (2) step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_aborted", int'(bus.aborted), 0);
    chk("rst_we", int'(bus.mem_we), 0);
    chk("rst_a", int'(bus.mem_a), 0);
    chk("rst_wd", int'(bus.mem_wd), 0);
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 256; i++) load(8'(i), 8'h00);

    for (int i = 0; i < 4; i++) load(8'h10 + 8'(i), 8'hA0 + 8'(i));
    c = cyc;
    go(0, 8'h10, 8'h20, 4, 8'h00);
    drain(40);
    chk("copy_done_lat", done_at - c, 9);
    for (int i = 0; i < 4; i++)
      chk("copy_data", int'(mem[8'h20 + 8'(i)]), 'hA0 + i);

    for (int i = 0; i < 4; i++) load(8'h10 + 8'(i), 8'(i + 1));
    w0 = wq.size();
    go(0, 8'h10, 8'h12, 4, 8'h00);
    drain(40);
    chk("ovl_first_wa", int'(wq[w0]), 'h15);
    for (int i = 0; i < 4; i++)
      chk("ovl_data", int'(mem[8'h12 + 8'(i)]), i + 1);

    load(8'h02, 8'hC3);
    b0 = busy_cnt;
    go(1, 8'h00, 8'hFE, 4, 8'h5A);
    drain(20);
    chk("wrap_busy", busy_cnt - b0, 4);
    chk("wrap_fe", int'(mem[8'hFE]), 'h5A);
    chk("wrap_ff", int'(mem[8'hFF]), 'h5A);
    chk("wrap_00", int'(mem[8'h00]), 'h5A);
    chk("wrap_01", int'(mem[8'h01]), 'h5A);
    chk("wrap_02", int'(mem[8'h02]), 'hC3);

    w0 = wq.size();
    c = cyc;
    go(1, 8'h00, 8'h30, 0, 8'h99);
    drain(10);
    chk("len0_lat", done_at - c, 1);
    chk("len0_writes", wq.size() - w0, 0);

    w0 = wq.size();
    b0 = busy_cnt;
    go(1, 8'h00, 8'h00, 256, 8'hE7);
    drain(400);
    chk("full_busy", busy_cnt - b0, 256);
    chk("full_writes", wq.size() - w0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'hE7) bad++;
    chk("full_data_bad", bad, 0);

    for (int i = 0; i < 8; i++) load(8'h40 + 8'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 8; i++) load(8'h80 + 8'(i), 8'h00);
    w0 = wq.size();
    d0 = done_at;
    go(0, 8'h40, 8'h80, 8, 8'h00);
    repeat (5) step();
    bus.abort = 1'b1;
    model_abort();
    step();
    bus.abort = 1'b0;
    drain(10);
    chk("ab_writes", wq.size() - w0, 2);
    chk("ab_b0", int'(mem[8'h80]), 'h11);
    chk("ab_b1", int'(mem[8'h81]), 'h22);
    chk("ab_b2", int'(mem[8'h82]), 'h00);
    chk("ab_no_done", done_at, d0);
    go(1, 8'h00, 8'h90, 2, 8'h77);
    drain(10);
    chk("ab_restart", int'(mem[8'h91]), 'h77);

    for (int i = 0; i < 10; i++) load(8'hA0 + 8'(i), 8'h00);
    w0 = wq.size();
    go(1, 8'h00, 8'hA0, 10, 8'h33);
    step();
    bus.mode = 0; bus.src = 8'h00; bus.len = 9'd5;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_we", int'(bus.mem_we), 0);
    drain(10);
    repeat (3) step();
    chk("rst_mid_writes", wq.size() - w0, 5);
    chk("rst_mid_a4", int'(mem[8'hA4]), 'h33);
    chk("rst_mid_a5", int'(mem[8'hA5]), 'h00);

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("model_image_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
